// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I decode definitions.
//   - XLEN, NOP_INSTR and the base opcode values
//   - imm_type_e: which immediate format an opcode uses
//   - ctrl_t: control bundle handed to execute
//   - dec_t / decode_op(): opcode -> control, immediate type and register usage
package riscv_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
    logic alu_src;
    logic illegal;
  } ctrl_t;

  typedef struct packed {
    ctrl_t     ctrl;
    imm_type_e imm_type;
    logic      rs1_used;
    logic      rs2_used;
  } dec_t;

  // Opcode decode. rd==x0 suppression of reg_write is applied by the caller,
  // since it depends on a field outside the opcode.
  function automatic dec_t decode_op(input logic [6:0] op);
    dec_t d;
    d          = '0;
    d.imm_type = IMM_NONE;
    d.rs1_used = 1'b1;
    d.rs2_used = 1'b0;
    case (op)
      OP_R: begin
        d.ctrl.reg_write = 1'b1;
        d.rs2_used       = 1'b1;
      end
      OP_IMM: begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.alu_src   = 1'b1;
        d.imm_type       = IMM_I;
      end
      OP_LOAD: begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.mem_read  = 1'b1;
        d.ctrl.alu_src   = 1'b1;
        d.imm_type       = IMM_I;
      end
      OP_STORE: begin
        d.ctrl.mem_write = 1'b1;
        d.ctrl.alu_src   = 1'b1;
        d.imm_type       = IMM_S;
        d.rs2_used       = 1'b1;
      end
      OP_BRANCH: begin
        d.ctrl.branch = 1'b1;
        d.imm_type    = IMM_B;
        d.rs2_used    = 1'b1;
      end
      OP_JAL: begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.jump      = 1'b1;
        d.imm_type       = IMM_J;
        d.rs1_used       = 1'b0;
      end
      OP_JALR: begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.jump      = 1'b1;
        d.ctrl.alu_src   = 1'b1;
        d.imm_type       = IMM_I;
      end
      OP_LUI, OP_AUIPC: begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.alu_src   = 1'b1;
        d.imm_type       = IMM_U;
        d.rs1_used       = 1'b0;
      end
      default: begin
        d.ctrl.illegal = 1'b1;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: ID/EX bundle between decode and execute.
//   master (decode): drives ex_valid and all registered operands/control,
//                    samples ex_ready.
//   slave (execute): the reverse.
interface decode_stage_if;
  logic        ex_ready;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_rs1_val;
  logic [31:0] ex_rs2_val;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5;
  logic [6:0]  ex_opcode;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_branch;
  logic        ex_jump;
  logic        ex_alu_src;
  logic        ex_illegal;

  modport master (
    input  ex_ready,
    output ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rd, ex_funct3,
           ex_funct7b5, ex_opcode, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_branch, ex_jump, ex_alu_src, ex_illegal
  );

  modport slave (
    output ex_ready,
    input  ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rd, ex_funct3,
           ex_funct7b5, ex_opcode, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_branch, ex_jump, ex_alu_src, ex_illegal
  );
endinterface

// File: rtl/decode_stage_imm_gen.sv
// imm_gen: combinational RV32I immediate generator.
//   instr    in  32  instruction word
//   imm_type in      immediate format (IMM_NONE gives zero)
//   imm      out 32  sign-extended immediate
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  input  imm_type_e   imm_type,
  output logic [31:0] imm
);

  // Format select; all signed formats extend from instr[31].
  always_comb begin
    imm = 32'h0000_0000;
    case (imm_type)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'h000};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode stage in front of the register file.
//   clk, reset (async, active-high)
//   fetch side : if_valid/if_instr/if_pc in, id_ready out, flush in
//   regfile    : readRegister1/2 out (from IF/ID), readData1/2 in
//   writeback  : wb_we/wb_rd/wb_data in, used for same-cycle bypass
//   ex_bus     : registered ID/EX contents with valid/ready handshake
// Inserts one bubble for a load-use dependency on the instruction in ID/EX.
module decode_stage
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [XLEN-1:0]   if_instr,
  input  logic [XLEN-1:0]   if_pc,
  output logic              id_ready,
  input  logic              flush,
  output logic [4:0]        readRegister1,
  output logic [4:0]        readRegister2,
  input  logic [XLEN-1:0]   readData1,
  input  logic [XLEN-1:0]   readData2,
  input  logic              wb_we,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  decode_stage_if.master    ex_bus
);

  // Register file writes on the same edge ID/EX captures, so an in-flight
  // writeback must be forwarded; x0 always reads as zero.
  function automatic logic [XLEN-1:0] sel_operand(
    input logic [4:0]      rs,
    input logic [XLEN-1:0] rf_data,
    input logic            we,
    input logic [4:0]      wrd,
    input logic [XLEN-1:0] wdata
  );
    if (rs == 5'd0) begin
      return {XLEN{1'b0}};
    end else if (we && (wrd != 5'd0) && (wrd == rs)) begin
      return wdata;
    end else begin
      return rf_data;
    end
  endfunction

  // IF/ID register
  logic            id_valid_r;
  logic [XLEN-1:0] id_instr_r;
  logic [XLEN-1:0] id_pc_r;

  // ID/EX register
  logic            ex_valid_r;
  logic [XLEN-1:0] ex_pc_r;
  logic [XLEN-1:0] ex_rs1_val_r;
  logic [XLEN-1:0] ex_rs2_val_r;
  logic [XLEN-1:0] ex_imm_r;
  logic [4:0]      ex_rd_r;
  logic [2:0]      ex_funct3_r;
  logic            ex_funct7b5_r;
  logic [6:0]      ex_opcode_r;
  ctrl_t           ex_ctrl_r;

  // Decode of the IF/ID contents
  logic [4:0]      rs1_s;
  logic [4:0]      rs2_s;
  logic [4:0]      rd_s;
  dec_t            dec_s;
  ctrl_t           ctrl_s;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] rs1_val_s;
  logic [XLEN-1:0] rs2_val_s;
  logic            hazard_s;
  logic            advance_s;

  assign rs1_s         = id_instr_r[19:15];
  assign rs2_s         = id_instr_r[24:20];
  assign rd_s          = id_instr_r[11:7];
  assign readRegister1 = rs1_s;
  assign readRegister2 = rs2_s;

  imm_gen u_imm_gen (
    .instr    (id_instr_r),
    .imm_type (dec_s.imm_type),
    .imm      (imm_s)
  );

  // Control decode, operand select, hazard and flow control.
  always_comb begin
    dec_s  = decode_op(id_instr_r[6:0]);
    ctrl_s = dec_s.ctrl;
    if (rd_s == 5'd0) begin
      ctrl_s.reg_write = 1'b0;
    end else begin
      ctrl_s.reg_write = dec_s.ctrl.reg_write;
    end
    rs1_val_s = sel_operand(rs1_s, readData1, wb_we, wb_rd, wb_data);
    rs2_val_s = sel_operand(rs2_s, readData2, wb_we, wb_rd, wb_data);
    hazard_s  = id_valid_r && ex_valid_r && ex_ctrl_r.mem_read && (ex_rd_r != 5'd0) &&
                ((dec_s.rs1_used && (ex_rd_r == rs1_s)) ||
                 (dec_s.rs2_used && (ex_rd_r == rs2_s)));
    advance_s = !ex_valid_r || ex_bus.ex_ready;
    id_ready  = !flush && (!id_valid_r || (advance_s && !hazard_s));
  end

  // IF/ID register: capture on accept, drain once the instruction moves on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_valid_r <= 1'b0;
      id_instr_r <= NOP_INSTR;
      id_pc_r    <= {XLEN{1'b0}};
    end else if (flush) begin
      id_valid_r <= 1'b0;
      id_instr_r <= NOP_INSTR;
    end else if (if_valid && id_ready) begin
      id_valid_r <= 1'b1;
      id_instr_r <= if_instr;
      id_pc_r    <= if_pc;
    end else if (advance_s && !hazard_s && id_valid_r) begin
      id_valid_r <= 1'b0;
    end
  end

  // ID/EX register: flush > bubble > load > hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_r    <= 1'b0;
      ex_pc_r       <= {XLEN{1'b0}};
      ex_rs1_val_r  <= {XLEN{1'b0}};
      ex_rs2_val_r  <= {XLEN{1'b0}};
      ex_imm_r      <= {XLEN{1'b0}};
      ex_rd_r       <= 5'd0;
      ex_funct3_r   <= 3'd0;
      ex_funct7b5_r <= 1'b0;
      ex_opcode_r   <= 7'd0;
      ex_ctrl_r     <= '0;
    end else if (flush) begin
      ex_valid_r <= 1'b0;
    end else if (advance_s && hazard_s) begin
      ex_valid_r <= 1'b0;
    end else if (advance_s) begin
      ex_valid_r    <= id_valid_r;
      ex_pc_r       <= id_pc_r;
      ex_rs1_val_r  <= rs1_val_s;
      ex_rs2_val_r  <= rs2_val_s;
      ex_imm_r      <= imm_s;
      ex_rd_r       <= rd_s;
      ex_funct3_r   <= id_instr_r[14:12];
      ex_funct7b5_r <= id_instr_r[30];
      ex_opcode_r   <= id_instr_r[6:0];
      ex_ctrl_r     <= ctrl_s;
    end
  end

  assign ex_bus.ex_valid     = ex_valid_r;
  assign ex_bus.ex_pc        = ex_pc_r;
  assign ex_bus.ex_rs1_val   = ex_rs1_val_r;
  assign ex_bus.ex_rs2_val   = ex_rs2_val_r;
  assign ex_bus.ex_imm       = ex_imm_r;
  assign ex_bus.ex_rd        = ex_rd_r;
  assign ex_bus.ex_funct3    = ex_funct3_r;
  assign ex_bus.ex_funct7b5  = ex_funct7b5_r;
  assign ex_bus.ex_opcode    = ex_opcode_r;
  assign ex_bus.ex_reg_write = ex_ctrl_r.reg_write;
  assign ex_bus.ex_mem_read  = ex_ctrl_r.mem_read;
  assign ex_bus.ex_mem_write = ex_ctrl_r.mem_write;
  assign ex_bus.ex_branch    = ex_ctrl_r.branch;
  assign ex_bus.ex_jump      = ex_ctrl_r.jump;
  assign ex_bus.ex_alu_src   = ex_ctrl_r.alu_src;
  assign ex_bus.ex_illegal   = ex_ctrl_r.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed self-checking bench for decode_stage.
module tb_decode_stage;

  logic        clk;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        flush;
  logic [4:0]  readRegister1;
  logic [4:0]  readRegister2;
  logic [31:0] readData1;
  logic [31:0] readData2;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int total_cnt;
  int bad_cnt;

  decode_stage_if ex_if ();

  decode_stage dut (
    .clk           (clk),
    .reset         (reset),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .id_ready      (id_ready),
    .flush         (flush),
    .readRegister1 (readRegister1),
    .readRegister2 (readRegister2),
    .readData1     (readData1),
    .readData2     (readData2),
    .wb_we         (wb_we),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .ex_bus        (ex_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
    if_valid = 1'b1;
    if_instr = instr;
    if_pc    = pc;
  endtask

  // packed control flags: reg_write, mem_read, mem_write, branch, jump, alu_src, illegal
  function automatic logic [31:0] ctrl_bits();
    return {25'd0, ex_if.ex_reg_write, ex_if.ex_mem_read, ex_if.ex_mem_write,
            ex_if.ex_branch, ex_if.ex_jump, ex_if.ex_alu_src, ex_if.ex_illegal};
  endfunction

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    reset = 1'b1; flush = 1'b0; if_valid = 1'b0; if_instr = 32'h0; if_pc = 32'h0;
    readData1 = 32'h0; readData2 = 32'h0; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
    ex_if.ex_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check_val("rst_ex_valid", {31'd0, ex_if.ex_valid}, 32'd0);
    check_val("rst_id_ready", {31'd0, id_ready}, 32'd1);
    check_val("rst_rr1", {27'd0, readRegister1}, 32'd0);
    check_val("rst_rr2", {27'd0, readRegister2}, 32'd0);
    check_val("rst_ctrl", ctrl_bits(), 32'd0);

    // addi x1,x0,5: x0 source must read zero even with junk on readData1
    offer(32'h0050_0093, 32'h0);
    tick();
    if_valid = 1'b0;
    readData1 = 32'h0000_1111;
    tick();
    check_val("addi_valid", {31'd0, ex_if.ex_valid}, 32'd1);
    check_val("addi_rd", {27'd0, ex_if.ex_rd}, 32'd1);
    check_val("addi_imm", ex_if.ex_imm, 32'd5);
    check_val("addi_rs1", ex_if.ex_rs1_val, 32'd0);
    check_val("addi_ctrl", ctrl_bits(), 32'b100_0010);

    // lw x2,0(x1) then add x3,x2,x2: one bubble
    offer(32'h0000_A103, 32'h4);
    tick();
    offer(32'h0021_01B3, 32'h8);
    check_val("lu_accept_add", {31'd0, id_ready}, 32'd1);
    tick();
    if_valid = 1'b0;
    check_val("lu_lw_valid", {31'd0, ex_if.ex_valid}, 32'd1);
    check_val("lu_lw_ctrl", ctrl_bits(), 32'b110_0010);
    check_val("lu_lw_funct3", {29'd0, ex_if.ex_funct3}, 32'd2);
    check_val("lu_stall_ready", {31'd0, id_ready}, 32'd0);
    check_val("lu_rr1", {27'd0, readRegister1}, 32'd2);
    check_val("lu_rr2", {27'd0, readRegister2}, 32'd2);
    tick();
    check_val("lu_bubble", {31'd0, ex_if.ex_valid}, 32'd0);
    check_val("lu_ready_after", {31'd0, id_ready}, 32'd1);
    readData1 = 32'h0000_0064;
    readData2 = 32'h0000_0064;
    tick();
    check_val("lu_add_valid", {31'd0, ex_if.ex_valid}, 32'd1);
    check_val("lu_add_rd", {27'd0, ex_if.ex_rd}, 32'd3);
    check_val("lu_add_pc", ex_if.ex_pc, 32'h8);
    check_val("lu_add_rs1", ex_if.ex_rs1_val, 32'h64);

    // add x4,x5,x6 with writeback of x5 in the same cycle
    offer(32'h0062_8233, 32'hC);
    tick();
    if_valid = 1'b0;
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
    readData1 = 32'h0; readData2 = 32'h0000_0777;
    tick();
    wb_we = 1'b0;
    check_val("byp_rs1", ex_if.ex_rs1_val, 32'hDEAD_BEEF);
    check_val("byp_rs2", ex_if.ex_rs2_val, 32'h0000_0777);
    check_val("byp_opcode", {25'd0, ex_if.ex_opcode}, 32'h33);

    // back-pressure from execute
    offer(32'h0010_0393, 32'h10);
    tick();
    offer(32'h0020_0413, 32'h14);
    tick();
    ex_if.ex_ready = 1'b0;
    offer(32'h0030_0493, 32'h18);
    #1;
    check_val("stall_ready", {31'd0, id_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("stall_valid", {31'd0, ex_if.ex_valid}, 32'd1);
      check_val("stall_rd", {27'd0, ex_if.ex_rd}, 32'd7);
      check_val("stall_imm", ex_if.ex_imm, 32'd1);
      check_val("stall_pc", ex_if.ex_pc, 32'h10);
      check_val("stall_idr", {31'd0, id_ready}, 32'd0);
    end
    ex_if.ex_ready = 1'b1;
    #1;
    check_val("release_ready", {31'd0, id_ready}, 32'd1);
    tick();
    if_valid = 1'b0;
    check_val("release_rd8", {27'd0, ex_if.ex_rd}, 32'd8);
    check_val("release_imm2", ex_if.ex_imm, 32'd2);
    tick();
    check_val("release_rd9", {27'd0, ex_if.ex_rd}, 32'd9);
    check_val("release_pc", ex_if.ex_pc, 32'h18);

    // flush with IF/ID and ID/EX both full
    offer(32'h0040_8513, 32'h1C);
    tick();
    offer(32'h0051_0593, 32'h20);
    tick();
    check_val("pre_flush_valid", {31'd0, ex_if.ex_valid}, 32'd1);
    check_val("pre_flush_rr1", {27'd0, readRegister1}, 32'd2);
    flush = 1'b1;
    offer(32'h0060_0613, 32'h24);
    #1;
    check_val("flush_ready", {31'd0, id_ready}, 32'd0);
    tick();
    flush = 1'b0;
    if_valid = 1'b0;
    check_val("flush_ex_valid", {31'd0, ex_if.ex_valid}, 32'd0);
    check_val("flush_rr1", {27'd0, readRegister1}, 32'd0);
    check_val("flush_rr2", {27'd0, readRegister2}, 32'd0);
    tick();
    check_val("flush_dropped", {31'd0, ex_if.ex_valid}, 32'd0);

    // beq x1,x2,-4
    offer(32'hFE20_8EE3, 32'h28);
    tick();
    if_valid = 1'b0;
    tick();
    check_val("beq_valid", {31'd0, ex_if.ex_valid}, 32'd1);
    check_val("beq_imm", ex_if.ex_imm, 32'hFFFF_FFFC);
    check_val("beq_ctrl", ctrl_bits(), 32'b000_1000);

    // sw x2,8(x1)
    offer(32'h0020_A423, 32'h2C);
    tick();
    if_valid = 1'b0;
    tick();
    check_val("sw_imm", ex_if.ex_imm, 32'd8);
    check_val("sw_ctrl", ctrl_bits(), 32'b001_0010);

    // unknown opcode 1111111 with rd=x1
    offer(32'h0000_00FF, 32'h30);
    tick();
    if_valid = 1'b0;
    tick();
    check_val("ill_valid", {31'd0, ex_if.ex_valid}, 32'd1);
    check_val("ill_ctrl", ctrl_bits(), 32'b000_0001);
    check_val("ill_imm", ex_if.ex_imm, 32'd0);

    // async reset in the middle of a stall
    offer(32'h0010_0393, 32'h34);
    tick();
    offer(32'h0020_0413, 32'h38);
    tick();
    if_valid = 1'b0;
    ex_if.ex_ready = 1'b0;
    tick();
    check_val("pre_rst_valid", {31'd0, ex_if.ex_valid}, 32'd1);
    check_val("pre_rst_idr", {31'd0, id_ready}, 32'd0);
    #2 reset = 1'b1;
    #1;
    check_val("mid_rst_valid", {31'd0, ex_if.ex_valid}, 32'd0);
    check_val("mid_rst_idr", {31'd0, id_ready}, 32'd1);
    check_val("mid_rst_rd", {27'd0, ex_if.ex_rd}, 32'd0);
    tick();
    reset = 1'b0;
    ex_if.ex_ready = 1'b1;

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- RV32I instruction-decode stage that sits directly upstream of the register file.
- Latches fetched instructions into an IF/ID register and drives readRegister1/readRegister2 from the rs1/rs2 fields.
- Consumes readData1/readData2, applies a same-cycle writeback bypass and x0 forcing, generates immediates and control, and registers everything into an ID/EX register using a valid/ready handshake.
- Detects load-use hazards and inserts one bubble per hazard.

Parameters:
- XLEN, 32, datapath width (fixed at 32 for RV32I).
- NOP_INSTR, 32'h00000013, instruction held in IF/ID at reset and after flush (addi x0,x0,0).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- if_valid  in  1  fetch presents an instruction
- if_instr  in  32  instruction word
- if_pc  in  32  instruction PC
- id_ready  out  1  stage accepts if_instr this cycle
- flush  in  1  branch/jump redirect; kill IF/ID and ID/EX
- readRegister1  out  5  rs1 address to register file
- readRegister2  out  5  rs2 address to register file
- readData1  in  32  register file async read data 1
- readData2  in  32  register file async read data 2
- wb_we  in  1  writeback write enable (same signal as the register file regWrite)
- wb_rd  in  5  writeback destination
- wb_data  in  32  writeback data
- ex_ready  in  1  execute stage accepts the ID/EX contents
- ex_valid  out  1  ID/EX holds a valid instruction
- ex_pc, ex_rs1_val, ex_rs2_val, ex_imm  out  32 each  registered operands
- ex_rd  out  5  destination register
- ex_funct3  out  3  funct3 field
- ex_funct7b5  out  1  instr[30]
- ex_opcode  out  7  opcode field
- ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_alu_src, ex_illegal  out  1 each  control

Behaviour:
- Reset (async): id_valid=0, id_instr=NOP_INSTR, id_pc=0. All ex_* outputs are 0, including ex_valid.
  - After reset, id_ready=1 and readRegister1/2=0.
- readRegister1 = id_instr[19:15] and readRegister2 = id_instr[24:20], both combinational from the IF/ID register.
- Operand select:
  - If rs==0: 0.
  - Else if wb_we && wb_rd!=0 && wb_rd==rs: wb_data.
  - Else: readData. The bypass is required because the register file writes on the same edge that ID/EX captures.
- Register use:
  - rs1_used: all opcodes except LUI, AUIPC, JAL.
  - rs2_used: R-type, store, branch.
- hazard = id_valid && ex_valid && ex_mem_read && ex_rd!=0 && ((rs1_used && ex_rd==rs1) || (rs2_used && ex_rd==rs2)).
- Flow control:
  - advance = !ex_valid || ex_ready.
  - id_ready = !flush && (!id_valid || (advance && !hazard)).
- Clock edge, in priority order:
  1. flush: id_valid<=0, id_instr<=NOP_INSTR, ex_valid<=0. if_instr that cycle is dropped.
  2. advance && hazard: ex_valid<=0 (bubble). IF/ID holds.
  3. advance: ex_valid<=id_valid and all ex_* fields load from decode.
  4. !advance: ID/EX holds, including operand values. The hazard cannot resolve while stalled.
- IF/ID load: if if_valid && id_ready, capture if_instr/if_pc and set id_valid<=1. Else if advance && !hazard && id_valid, clear id_valid<=0. Else hold.
- Immediates: sign-extend from instr[31].
  - I: [31:20]. S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}. U: {[31:12],12'b0}. J: {[31],[19:12],[20],[30:21],0}.
  - R-type: imm=0.
- Control by opcode:
  - R (0110011): reg_write.
  - I-ALU (0010011): reg_write, alu_src.
  - LOAD (0000011): reg_write, mem_read, alu_src.
  - STORE (0100011): mem_write, alu_src.
  - BRANCH (1100011): branch.
  - JAL (1101111) and JALR (1100111): reg_write, jump; JALR also alu_src.
  - LUI and AUIPC: reg_write, alu_src.
  - Any other opcode: ex_illegal=1, all other control 0.
  - ex_reg_write is forced to 0 when rd==0.
- Reset asserted mid-stall or mid-hazard clears all valids immediately. There is no partial state.

Decomposition:
- Shared package riscv_pkg: opcode localparams, NOP_INSTR, immediate-type enum (IMM_I/S/B/U/J/NONE), control-bundle struct.
- Sub-module imm_gen (instr in, imm-type in, 32-bit imm out) is purely combinational.
- Hazard and bypass logic stay inline.

Test Plan:
- After reset, feed addi x1,x0,5 (32'h00500093) at pc 0 with ex_ready=1 -> next cycle ex_valid=1, ex_rd=1, ex_imm=5, ex_rs1_val=0, ex_reg_write=1, ex_alu_src=1.
- Feed lw x2,0(x1) then add x3,x2,x2 back to back -> exactly one cycle with ex_valid=0 while id_ready=0, then add issues with readRegister1=readRegister2=2.
- Decode add x4,x5,x6 while wb_we=1, wb_rd=5, wb_data=32'hDEADBEEF, readData1=0 -> ex_rs1_val=32'hDEADBEEF, ex_rs2_val=readData2.
- Hold ex_ready=0 for 3 cycles with ex_valid=1 -> all ex_* stable, id_ready=0 once IF/ID is full, no instruction lost when ex_ready returns to 1.
- Assert flush with IF/ID and ID/EX both valid -> next cycle ex_valid=0, readRegister1/2=0, and the instruction offered during the flush cycle is not accepted.
- Feed beq x1,x2,-4 (32'hFE208EE3) -> ex_imm=32'hFFFFFFFC, ex_branch=1, ex_reg_write=0. Feed opcode 7'b1111111 -> ex_illegal=1, all other control 0.
